// File: rtl/rv64_decode_exec_stage_pkg.sv
// Shared RV64I decode constants: type codes, opcodes, func3 codes, select keys.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
// Contents: itype_e, OPC_* opcodes, F3_* func3 codes, operand/writeback select
// keys, and load_extend() which sizes raw load data per func3.
package rv64_decode_exec_stage_pkg;

   localparam int XLEN_C = 64;

   typedef enum logic [3:0] {
      IT_R    = 4'b0000,
      IT_I    = 4'b0001,
      IT_U    = 4'b0010,
      IT_B    = 4'b0011,
      IT_S    = 4'b0100,
      IT_LOAD = 4'b1001,
      IT_JUMP = 4'b1011,
      IT_INV  = 4'b1111
   } itype_e;

   localparam logic [6:0] OPC_OP        = 7'h33;
   localparam logic [6:0] OPC_OP_IMM    = 7'h13;
   localparam logic [6:0] OPC_OP_32     = 7'h3B;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
   localparam logic [6:0] OPC_LUI       = 7'h37;
   localparam logic [6:0] OPC_AUIPC     = 7'h17;
   localparam logic [6:0] OPC_JAL       = 7'h6F;
   localparam logic [6:0] OPC_JALR      = 7'h67;
   localparam logic [6:0] OPC_BRANCH    = 7'h63;
   localparam logic [6:0] OPC_LOAD      = 7'h03;
   localparam logic [6:0] OPC_STORE     = 7'h23;

   // ALU func3
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // Branch func3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Load func3
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   // Operand A select keys (anything else selects rs1_data)
   localparam logic [1:0] ASEL_RS1  = 2'd0;
   localparam logic [1:0] ASEL_PC   = 2'd1;
   localparam logic [1:0] ASEL_ZERO = 2'd2;

   // Writeback select keys (anything else selects the ALU result)
   localparam logic [1:0] WBSEL_ALU  = 2'd0;
   localparam logic [1:0] WBSEL_LINK = 2'd1;
   localparam logic [1:0] WBSEL_LOAD = 2'd2;

   function automatic logic [63:0] load_extend(input logic [2:0] f3, input logic [63:0] d);
      logic [63:0] r;
      case (f3)
         F3_LB:   r = {{56{d[7]}}, d[7:0]};
         F3_LH:   r = {{48{d[15]}}, d[15:0]};
         F3_LW:   r = {{32{d[31]}}, d[31:0]};
         F3_LD:   r = d;
         F3_LBU:  r = {56'b0, d[7:0]};
         F3_LHU:  r = {48'b0, d[15:0]};
         F3_LWU:  r = {32'b0, d[31:0]};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rv64_decode_exec_stage_key_mux.sv
// Keyed lookup: returns the data entry whose key matches i_key, else i_default.
// Latency: combinational.
// Backpressure: none.
// Ports: i_key (lookup key), i_keys (NR_KEY packed keys, entry 0 in the LSBs),
// i_data (NR_KEY packed data words, same order), i_default, o_data.
module key_mux #(
   parameter int NR_KEY   = 2,
   parameter int KEY_LEN  = 2,
   parameter int DATA_LEN = 64
) (
   input  logic [KEY_LEN-1:0]         i_key,
   input  logic [NR_KEY*KEY_LEN-1:0]  i_keys,
   input  logic [NR_KEY*DATA_LEN-1:0] i_data,
   input  logic [DATA_LEN-1:0]        i_default,
   output logic [DATA_LEN-1:0]        o_data
);

   // Keys are expected to be unique; with duplicates the highest entry wins.
   always_comb begin
      o_data = i_default;
      for (int k = 0; k < NR_KEY; k++) begin
         if (i_keys[k*KEY_LEN +: KEY_LEN] == i_key)
            o_data = i_data[k*DATA_LEN +: DATA_LEN];
      end
   end

endmodule

// File: rtl/rv64_decode_exec_stage.sv
// RV64I decode + execute: immediate, ALU, branch decision, next PC, writeback data.
// Latency: 1 cycle (all outputs registered except rs1_idx/rs2_idx).
// Backpressure: none; registered outputs load when in_valid=1 and hold otherwise.
// Ports: clk/rst (sync, active high); in_valid, instr, pc, rs1_data, rs2_data,
// load_data in; rs1_idx/rs2_idx (combinational) and the registered out_valid,
// rd_idx, itype, imm, alu_result, wb_en, wb_data, mem_we/wdata/size/re, npc.
module rv64_decode_exec_stage
   import rv64_decode_exec_stage_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] load_data,
   output logic [4:0]      rs1_idx,
   output logic [4:0]      rs2_idx,
   output logic            out_valid,
   output logic [4:0]      rd_idx,
   output logic [3:0]      itype,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] alu_result,
   output logic            wb_en,
   output logic [XLEN-1:0] wb_data,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_wdata,
   output logic [1:0]      mem_size,
   output logic            mem_re,
   output logic [XLEN-1:0] npc
);

   // ---------------- decode ----------------
   logic [6:0]      w_opcode;
   logic [2:0]      w_f3;
   logic            w_f7;
   logic [4:0]      w_rd;
   logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   itype_e          w_itype;
   logic [XLEN-1:0] w_imm;
   logic            w_is_w;
   logic            w_force_add;
   logic            w_b_imm;
   logic [1:0]      w_a_sel;
   logic [1:0]      w_wb_sel;

   assign rs1_idx  = instr[19:15];
   assign rs2_idx  = instr[24:20];
   assign w_opcode = instr[6:0];
   assign w_f3     = instr[14:12];
   assign w_f7     = instr[30];
   assign w_rd     = instr[11:7];

   assign w_imm_i = {{52{instr[31]}}, instr[31:20]};
   assign w_imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
   assign w_imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign w_imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
   assign w_imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      w_itype     = IT_INV;
      w_imm       = '0;
      w_is_w      = 1'b0;
      w_force_add = 1'b1;
      w_b_imm     = 1'b0;
      w_a_sel     = ASEL_RS1;
      w_wb_sel    = WBSEL_ALU;
      case (w_opcode)
         OPC_OP: begin
            w_itype = IT_R; w_force_add = 1'b0;
         end
         OPC_OP_32: begin
            w_itype = IT_R; w_force_add = 1'b0; w_is_w = 1'b1;
         end
         OPC_OP_IMM: begin
            w_itype = IT_I; w_force_add = 1'b0; w_imm = w_imm_i; w_b_imm = 1'b1;
         end
         OPC_OP_IMM_32: begin
            w_itype = IT_I; w_force_add = 1'b0; w_imm = w_imm_i; w_b_imm = 1'b1; w_is_w = 1'b1;
         end
         OPC_LUI: begin
            w_itype = IT_U; w_imm = w_imm_u; w_b_imm = 1'b1; w_a_sel = ASEL_ZERO;
         end
         OPC_AUIPC: begin
            w_itype = IT_U; w_imm = w_imm_u; w_b_imm = 1'b1; w_a_sel = ASEL_PC;
         end
         OPC_BRANCH: begin
            w_itype = IT_B; w_imm = w_imm_b;
         end
         OPC_STORE: begin
            w_itype = IT_S; w_imm = w_imm_s; w_b_imm = 1'b1;
         end
         OPC_LOAD: begin
            w_itype = IT_LOAD; w_imm = w_imm_i; w_b_imm = 1'b1; w_wb_sel = WBSEL_LOAD;
         end
         OPC_JAL: begin
            w_itype = IT_JUMP; w_imm = w_imm_j; w_b_imm = 1'b1; w_wb_sel = WBSEL_LINK;
         end
         OPC_JALR: begin
            w_itype = IT_JUMP; w_imm = w_imm_i; w_b_imm = 1'b1; w_wb_sel = WBSEL_LINK;
         end
         default: ;
      endcase
   end

   // ---------------- operand select ----------------
   logic [XLEN-1:0] w_alu_a, w_alu_b;

   key_mux #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(XLEN)) u_a_mux (
      .i_key     (w_a_sel),
      .i_keys    ({ASEL_ZERO, ASEL_PC}),
      .i_data    ({{XLEN{1'b0}}, pc}),
      .i_default (rs1_data),
      .o_data    (w_alu_a)
   );

   key_mux #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(XLEN)) u_b_mux (
      .i_key     (w_b_imm),
      .i_keys    (1'b1),
      .i_data    (w_imm),
      .i_default (rs2_data),
      .o_data    (w_alu_b)
   );

   // ---------------- ALU ----------------
   logic [2:0]      w_alu_op;
   logic            w_sub;
   logic [31:0]     w_a32, w_b32, w_r32;
   logic [XLEN-1:0] w_r64, w_alu_res;

   assign w_alu_op = w_force_add ? F3_ADD : w_f3;
   assign w_sub    = !w_force_add && (w_itype == IT_R) && w_f7;
   assign w_a32    = w_alu_a[31:0];
   assign w_b32    = w_alu_b[31:0];

   // Arithmetic right shifts are kept in their own if-branches so the signed
   // operand never ends up in an unsigned (ternary) context.
   always_comb begin
      w_r64 = '0;
      w_r32 = '0;
      case (w_alu_op)
         F3_ADD: begin
            if (w_sub) begin
               w_r64 = w_alu_a - w_alu_b; w_r32 = w_a32 - w_b32;
            end else begin
               w_r64 = w_alu_a + w_alu_b; w_r32 = w_a32 + w_b32;
            end
         end
         F3_SLL: begin
            w_r64 = w_alu_a << w_alu_b[5:0]; w_r32 = w_a32 << w_alu_b[4:0];
         end
         F3_SLT: begin
            w_r64 = {63'b0, $signed(w_alu_a) < $signed(w_alu_b)};
            w_r32 = {31'b0, $signed(w_a32) < $signed(w_b32)};
         end
         F3_SLTU: begin
            w_r64 = {63'b0, w_alu_a < w_alu_b};
            w_r32 = {31'b0, w_a32 < w_b32};
         end
         F3_XOR: begin
            w_r64 = w_alu_a ^ w_alu_b; w_r32 = w_a32 ^ w_b32;
         end
         F3_SR: begin
            if (w_f7) begin
               w_r64 = $signed(w_alu_a) >>> w_alu_b[5:0];
               w_r32 = $signed(w_a32) >>> w_alu_b[4:0];
            end else begin
               w_r64 = w_alu_a >> w_alu_b[5:0];
               w_r32 = w_a32 >> w_alu_b[4:0];
            end
         end
         F3_OR: begin
            w_r64 = w_alu_a | w_alu_b; w_r32 = w_a32 | w_b32;
         end
         default: begin
            w_r64 = w_alu_a & w_alu_b; w_r32 = w_a32 & w_b32;
         end
      endcase
   end

   assign w_alu_res = w_is_w ? {{32{w_r32[31]}}, w_r32} : w_r64;

   // ---------------- branch / next PC ----------------
   logic            w_cond, w_taken;
   logic [XLEN-1:0] w_pc_plus4, w_pc_imm, w_npc;

   always_comb begin
      case (w_f3)
         F3_BEQ:  w_cond = (rs1_data == rs2_data);
         F3_BNE:  w_cond = (rs1_data != rs2_data);
         F3_BLT:  w_cond = ($signed(rs1_data) <  $signed(rs2_data));
         F3_BGE:  w_cond = ($signed(rs1_data) >= $signed(rs2_data));
         F3_BLTU: w_cond = (rs1_data <  rs2_data);
         F3_BGEU: w_cond = (rs1_data >= rs2_data);
         default: w_cond = 1'b0;
      endcase
   end

   assign w_taken    = (w_itype == IT_B) && w_cond;
   assign w_pc_plus4 = pc + 64'd4;
   assign w_pc_imm   = pc + w_imm;

   // JALR target reuses the ALU sum (rs1 + imm is forced to ADD for jumps).
   always_comb begin
      if (w_opcode == OPC_JALR)
         w_npc = {w_alu_res[XLEN-1:1], 1'b0};
      else if ((w_opcode == OPC_JAL) || w_taken)
         w_npc = w_pc_imm;
      else
         w_npc = w_pc_plus4;
   end

   // ---------------- writeback ----------------
   logic [XLEN-1:0] w_wb_data;
   logic            w_wb_en;

   key_mux #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(XLEN)) u_wb_mux (
      .i_key     (w_wb_sel),
      .i_keys    ({WBSEL_LOAD, WBSEL_LINK}),
      .i_data    ({load_extend(w_f3, load_data), w_pc_plus4}),
      .i_default (w_alu_res),
      .o_data    (w_wb_data)
   );

   assign w_wb_en = ((w_itype == IT_R) || (w_itype == IT_I) || (w_itype == IT_U) ||
                     (w_itype == IT_LOAD) || (w_itype == IT_JUMP)) && (w_rd != 5'd0);

   // ---------------- output registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         rd_idx     <= '0;
         itype      <= '0;
         imm        <= '0;
         alu_result <= '0;
         wb_en      <= 1'b0;
         wb_data    <= '0;
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
         mem_size   <= '0;
         mem_re     <= 1'b0;
         npc        <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            rd_idx     <= w_rd;
            itype      <= w_itype;
            imm        <= w_imm;
            alu_result <= w_alu_res;
            wb_en      <= w_wb_en;
            wb_data    <= w_wb_data;
            mem_we     <= (w_itype == IT_S);
            mem_wdata  <= rs2_data;
            mem_size   <= w_f3[1:0];
            mem_re     <= (w_itype == IT_LOAD);
            npc        <= w_npc;
         end
      end
   end

endmodule

// File: tb/tb_rv64_decode_exec_stage.sv
// Self-checking bench for rv64_decode_exec_stage: vector table driven through
// a scoreboard queue, plus reset-state, hold and mid-stream reset sequences.
module tb_rv64_decode_exec_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] instr;
   logic [63:0] pc, rs1_data, rs2_data, load_data;
   logic [4:0]  rs1_idx, rs2_idx, rd_idx;
   logic        out_valid, wb_en, mem_we, mem_re;
   logic [3:0]  itype;
   logic [63:0] imm, alu_result, wb_data, mem_wdata, npc;
   logic [1:0]  mem_size;

   always #5 clk = ~clk;

   rv64_decode_exec_stage #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc(pc),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .load_data(load_data),
      .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .out_valid(out_valid), .rd_idx(rd_idx),
      .itype(itype), .imm(imm), .alu_result(alu_result), .wb_en(wb_en),
      .wb_data(wb_data), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_size(mem_size), .mem_re(mem_re), .npc(npc)
   );

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc, rs1, rs2, ld;
      logic [3:0]  itype;
      logic [4:0]  rd;
      logic [63:0] imm, alu;
      logic        wb_en;
      logic [63:0] wb;
      logic        we, re;
      logic [63:0] npc;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   vec_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic [31:0] i, input logic [63:0] p, r1, r2, l,
                               input logic [3:0] t, input logic [4:0] rd,
                               input logic [63:0] im, al, input logic we_n,
                               input logic [63:0] wb, input logic we, re,
                               input logic [63:0] np);
      vec_t v;
      v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2; v.ld = l;
      v.itype = t; v.rd = rd; v.imm = im; v.alu = al; v.wb_en = we_n;
      v.wb = wb; v.we = we; v.re = re; v.npc = np;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
      end
   endtask

   // Scoreboard consumer: every registered output beat is matched to the
   // oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_output: got out_valid=1 instr pc npc=0x%h, expected no output", npc);
         end else begin
            mon_e = sb.pop_front();
            chk("itype",      itype,      mon_e.itype);
            chk("rd_idx",     rd_idx,     mon_e.rd);
            chk("imm",        imm,        mon_e.imm);
            chk("alu_result", alu_result, mon_e.alu);
            chk("wb_en",      wb_en,      mon_e.wb_en);
            chk("wb_data",    wb_data,    mon_e.wb);
            chk("mem_we",     mem_we,     mon_e.we);
            chk("mem_re",     mem_re,     mon_e.re);
            chk("mem_size",   mem_size,   {62'b0, mon_e.instr[13:12]});
            chk("mem_wdata",  mem_wdata,  mon_e.rs2);
            chk("npc",        npc,        mon_e.npc);
         end
      end
   end

   task automatic drive(input vec_t v, input bit push);
      @(negedge clk);
      instr = v.instr; pc = v.pc; rs1_data = v.rs1; rs2_data = v.rs2; load_data = v.ld;
      in_valid = 1'b1;
      if (push) sb.push_back(v);
      #1;
      chk("rs1_idx", rs1_idx, {59'b0, v.instr[19:15]});
      chk("rs2_idx", rs2_idx, {59'b0, v.instr[24:20]});
   endtask

   task automatic drain();
      for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: got %0d outstanding results, expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; instr = '0; pc = '0;
      rs1_data = '0; rs2_data = '0; load_data = '0;

      //          instr         pc            rs1                   rs2                   load                  it    rd  imm                   alu                   wbe wb                    we re npc
      vecs.push_back(mk(32'h00500093, 64'h1000, 64'h0, 64'h55, 64'h0, 4'h1, 5'd1, 64'h5, 64'h5, 1, 64'h5, 0, 0, 64'h1004));
      vecs.push_back(mk(32'h402081b3, 64'h1000, 64'h3, 64'h5, 64'h0, 4'h0, 5'd3, 64'h0, 64'hFFFFFFFFFFFFFFFE, 1, 64'hFFFFFFFFFFFFFFFE, 0, 0, 64'h1004));
      vecs.push_back(mk(32'h002081b3, 64'h1000, 64'h3, 64'h5, 64'h0, 4'h0, 5'd3, 64'h0, 64'h8, 1, 64'h8, 0, 0, 64'h1004));
      vecs.push_back(mk(32'h002081bb, 64'h1000, 64'h7FFFFFFF, 64'h1, 64'h0, 4'h0, 5'd3, 64'h0, 64'hFFFFFFFF80000000, 1, 64'hFFFFFFFF80000000, 0, 0, 64'h1004));
      vecs.push_back(mk(32'h123452b7, 64'h1000, 64'hDEAD, 64'h0, 64'h0, 4'h2, 5'd5, 64'h12345000, 64'h12345000, 1, 64'h12345000, 0, 0, 64'h1004));
      vecs.push_back(mk(32'h00208863, 64'h80000000, 64'h7, 64'h7, 64'h0, 4'h3, 5'd16, 64'h10, 64'hE, 0, 64'hE, 0, 0, 64'h80000010));
      vecs.push_back(mk(32'h00208863, 64'h80000000, 64'h7, 64'h8, 64'h0, 4'h3, 5'd16, 64'h10, 64'hF, 0, 64'hF, 0, 0, 64'h80000004));
      vecs.push_back(mk(32'h008000ef, 64'h80000000, 64'h100, 64'h0, 64'h0, 4'hB, 5'd1, 64'h8, 64'h108, 1, 64'h80000004, 0, 0, 64'h80000008));
      vecs.push_back(mk(32'h00010083, 64'h1000, 64'h2000, 64'h0, 64'h80, 4'h9, 5'd1, 64'h0, 64'h2000, 1, 64'hFFFFFFFFFFFFFF80, 0, 1, 64'h1004));
      vecs.push_back(mk(32'h0020b423, 64'h1000, 64'h1000, 64'hCAFEBABE12345678, 64'h0, 4'h4, 5'd8, 64'h8, 64'h1008, 0, 64'h1008, 1, 0, 64'h1004));
      vecs.push_back(mk(32'h0000057F, 64'h1000, 64'h0, 64'h0, 64'h0, 4'hF, 5'd10, 64'h0, 64'h0, 0, 64'h0, 0, 0, 64'h1004));
      vecs.push_back(mk(32'h4280D113, 64'h1000, 64'h8000000000000000, 64'h0, 64'h0, 4'h1, 5'd2, 64'h428, 64'hFFFFFFFFFF800000, 1, 64'hFFFFFFFFFF800000, 0, 0, 64'h1004));
      vecs.push_back(mk(32'h4020D1BB, 64'h1000, 64'h80000000, 64'h24, 64'h0, 4'h0, 5'd3, 64'h0, 64'hFFFFFFFFF8000000, 1, 64'hFFFFFFFFF8000000, 0, 0, 64'h1004));
      vecs.push_back(mk(32'h005100E7, 64'h1000, 64'h3000, 64'h0, 64'h0, 4'hB, 5'd1, 64'h5, 64'h3005, 1, 64'h1004, 0, 0, 64'h3004));
      vecs.push_back(mk(32'hFE20CEE3, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 4'h3, 5'd29, 64'hFFFFFFFFFFFFFFFC, 64'h0, 0, 64'h0, 0, 0, 64'hFFFFFFFFFFFFFFFC));
      vecs.push_back(mk(32'hFE20EEE3, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 4'h3, 5'd29, 64'hFFFFFFFFFFFFFFFC, 64'h0, 0, 64'h0, 0, 0, 64'h4));
      vecs.push_back(mk(32'h00012203, 64'h1000, 64'h40, 64'h0, 64'h1234567880000001, 4'h9, 5'd4, 64'h0, 64'h40, 1, 64'hFFFFFFFF80000001, 0, 1, 64'h1004));
      vecs.push_back(mk(32'h00014203, 64'h1000, 64'h40, 64'h0, 64'hAAAAAAAAAAAAAAFF, 4'h9, 5'd4, 64'h0, 64'h40, 1, 64'hFF, 0, 1, 64'h1004));
      vecs.push_back(mk(32'h00100013, 64'h1000, 64'h0, 64'h0, 64'h0, 4'h1, 5'd0, 64'h1, 64'h1, 0, 64'h1, 0, 0, 64'h1004));
      vecs.push_back(mk(32'h80000297, 64'h1000, 64'h0, 64'h0, 64'h0, 4'h2, 5'd5, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80001000, 1, 64'hFFFFFFFF80001000, 0, 0, 64'h1004));

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 64'h0);
      chk("rst_alu",       alu_result, 64'h0);
      chk("rst_npc",       npc, 64'h0);
      chk("rst_wb_en",     wb_en, 64'h0);
      chk("rst_wb_data",   wb_data, 64'h0);
      rst = 1'b0;

      // Back-to-back table vectors
      for (int i = 0; i < vecs.size(); i++) drive(vecs[i], 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      drain();

      // Hold: load the add vector, then idle with different inputs
      drive(vecs[2], 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      instr = vecs[0].instr; pc = 64'h5000; rs1_data = 64'h77; rs2_data = 64'h99;
      drain();
      repeat (2) @(negedge clk);
      chk("hold_out_valid", out_valid,  64'h0);
      chk("hold_alu",       alu_result, 64'h8);
      chk("hold_wb_data",   wb_data,    64'h8);
      chk("hold_npc",       npc,        64'h1004);
      chk("hold_rd_idx",    rd_idx,     64'h3);

      // Reset asserted mid-stream with in_valid=1
      rst = 1'b1;
      drive(vecs[4], 1'b0);
      @(negedge clk);
      chk("mrst_out_valid", out_valid,  64'h0);
      chk("mrst_itype",     itype,      64'h0);
      chk("mrst_rd_idx",    rd_idx,     64'h0);
      chk("mrst_imm",       imm,        64'h0);
      chk("mrst_alu",       alu_result, 64'h0);
      chk("mrst_wb_en",     wb_en,      64'h0);
      chk("mrst_wb_data",   wb_data,    64'h0);
      chk("mrst_mem",       {mem_we, mem_re, mem_size}, 64'h0);
      chk("mrst_mem_wdata", mem_wdata,  64'h0);
      chk("mrst_npc",       npc,        64'h0);
      rst = 1'b0;
      in_valid = 1'b0;

      // Recovery after reset
      drive(vecs[7], 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
